// File: rtl/rf_writeback_queue.sv
// Writeback FIFO feeding the register file's single write port; decode reads win, writes drain in idle slots.
// Optional: define RF_WBQ_COALESCE_EN to merge a push into the youngest entry when it targets the same register.
module rf_writeback_queue #(
   parameter int RF_ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH       = 16,
   parameter int DEPTH            = 4,
   parameter int MAX_STALL        = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push_valid,
   output logic                           push_ready,
   input  logic [RF_ADDRESS_WIDTH-1:0]    push_rd,
   input  logic [DATA_WIDTH-1:0]          push_data,
   input  logic                           rd_req,
   output logic                           rf_we,
   output logic [RF_ADDRESS_WIDTH-1:0]    rf_rd,
   output logic [DATA_WIDTH-1:0]          rf_data,
   output logic                           rd_grant,
   output logic [2**RF_ADDRESS_WIDTH-1:0] pending_mask,
   output logic [$clog2(DEPTH):0]         count,
   output logic                           full,
   output logic                           empty
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int STALL_W = $clog2(MAX_STALL + 1);

   logic [RF_ADDRESS_WIDTH-1:0] rd_mem   [DEPTH];
   logic [DATA_WIDTH-1:0]       data_mem [DEPTH];
   logic [PTR_W-1:0]            head, tail, last;
   logic [STALL_W-1:0]          stall_cnt;
   logic                        pop, accept, alloc, coalesce;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign last     = tail - PTR_W'(1);
   assign pop      = !empty && (!rd_req || stall_cnt == STALL_W'(MAX_STALL));
   assign rd_grant = rd_req && !pop;

`ifdef RF_WBQ_COALESCE_EN
   // Merging into an entry that is leaving this cycle would lose the data, so allocate instead.
   assign coalesce = !empty && (push_rd != '0) && (rd_mem[last] == push_rd)
                     && !(pop && count == CNT_W'(1));
`else
   assign coalesce = 1'b0;
`endif

   assign push_ready = !full || coalesce;
   assign accept     = push_valid && push_ready && (push_rd != '0);
   assign alloc      = accept && !coalesce;

   // NOTE: storage is not reset; validity comes from head/count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (alloc) begin
         rd_mem[tail]   <= push_rd;
         data_mem[tail] <= push_data;
      end else if (accept) begin
         data_mem[last] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         stall_cnt <= '0;
         rf_we     <= 1'b0;
         rf_rd     <= '0;
         rf_data   <= '0;
      end else begin
         if (alloc) tail <= tail + PTR_W'(1);
         if (pop)   head <= head + PTR_W'(1);
         count <= count + CNT_W'(alloc) - CNT_W'(pop);

         if (empty || pop)
            stall_cnt <= '0;
         else if (rd_req && stall_cnt != STALL_W'(MAX_STALL))
            stall_cnt <= stall_cnt + STALL_W'(1);

         rf_we <= pop;
         if (pop) begin
            rf_rd   <= rd_mem[head];
            rf_data <= data_mem[head];
         end
      end
   end

   // NOTE: defaulting the whole mask first keeps this block free of inferred latches.
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < count)
            pending_mask[rd_mem[head + PTR_W'(i)]] = 1'b1;
      end
      if (rf_we)
         pending_mask[rf_rd] = 1'b1;
   end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Randomized scoreboard bench for rf_writeback_queue against a queue-based behavioural model.
module tb_rf_writeback_queue;

   localparam int AW        = 5;
   localparam int DW        = 16;
   localparam int DEPTH     = 4;
   localparam int MAX_STALL = 3;

   typedef struct packed {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
   } wb_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            push_valid = 1'b0;
   logic            push_ready;
   logic [AW-1:0]   push_rd = '0;
   logic [DW-1:0]   push_data = '0;
   logic            rd_req = 1'b0;
   logic            rf_we;
   logic [AW-1:0]   rf_rd;
   logic [DW-1:0]   rf_data;
   logic            rd_grant;
   logic [2**AW-1:0] pending_mask;
   logic [$clog2(DEPTH):0] count;
   logic            full;
   logic            empty;

   rf_writeback_queue #(
      .RF_ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_STALL(MAX_STALL)
   ) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_ready(push_ready), .push_rd(push_rd), .push_data(push_data),
      .rd_req(rd_req),
      .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
      .rd_grant(rd_grant), .pending_mask(pending_mask),
      .count(count), .full(full), .empty(empty)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: pending entries, expected register-file writes, stall age, last write.
   wb_t           mq[$];
   wb_t           exp_q[$];
   int            stall = 0;
   bit            m_we = 1'b0;
   logic [AW-1:0] m_wrd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // One cycle: drive inputs, compare combinational/registered outputs, advance model.
   task automatic step(input bit pv, input logic [AW-1:0] prd, input logic [DW-1:0] pd, input bit rr);
      bit            m_pop, m_coal, m_ready;
      logic [31:0]   m_mask;
      wb_t           head;
      @(negedge clk);
      push_valid = pv; push_rd = prd; push_data = pd; rd_req = rr;
      #1;
      m_pop  = (mq.size() > 0) && (!rr || stall == MAX_STALL);
      m_coal = 1'b0;
`ifdef RF_WBQ_COALESCE_EN
      m_coal = pv && (prd != 0) && (mq.size() > 0) && (mq[mq.size()-1].rd == prd)
               && !(m_pop && mq.size() == 1);
`endif
      m_ready = (mq.size() < DEPTH) || m_coal;
      m_mask = '0;
      foreach (mq[i]) m_mask[mq[i].rd] = 1'b1;
      if (m_we) m_mask[m_wrd] = 1'b1;

      check("rd_grant",     32'(rd_grant),   32'(rr && !m_pop));
      check("push_ready",   32'(push_ready), 32'(m_ready));
      check("count",        32'(count),      32'(mq.size()));
      check("empty",        32'(empty),      32'(mq.size() == 0));
      check("full",         32'(full),       32'(mq.size() == DEPTH));
      check("pending_mask", pending_mask,    m_mask);

      if (mq.size() > 0) head = mq[0];
      else head = '0;
      if (mq.size() == 0 || m_pop) stall = 0;
      else if (rr && stall < MAX_STALL) stall++;
      if (pv && m_ready && prd != 0) begin
         if (m_coal) mq[mq.size()-1].data = pd;
         else mq.push_back('{rd: prd, data: pd});
      end
      if (m_pop) begin
         exp_q.push_back(head);
         void'(mq.pop_front());
         m_wrd = head.rd;
      end
      m_we = m_pop;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; push_valid = 1'b0; rd_req = 1'b0;
      mq.delete(); stall = 0; m_we = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_count", 32'(count),     32'd0);
      check("rst_empty", 32'(empty),     32'd1);
      check("rst_full",  32'(full),      32'd0);
      check("rst_we",    32'(rf_we),     32'd0);
      check("rst_mask",  pending_mask,   32'd0);
      check("rst_ready", 32'(push_ready), 32'd1);
   endtask

   // Monitor: every register-file write must match the oldest expected write.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_write: rd=%0d data=0x%0h with nothing expected at %0t",
                        rf_rd, rf_data, $time);
            end else begin
               e = exp_q.pop_front();
               check("wr_rd",   32'(rf_rd),   32'(e.rd));
               check("wr_data", 32'(rf_data), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();

      // Fill rd=1..4 under constant read pressure until a forced write lands, then reset mid-flight.
      for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), DW'(16'h1000 + i), 1'b1);
      step(1'b0, '0, '0, 1'b1);
      do_reset();

      // Latency: write appears two edges after the push edge.
      step(1'b1, AW'(5), 16'hBEEF, 1'b0);
      step(1'b0, '0, '0, 1'b0);
      @(posedge clk); #1;
      check("lat_we",   32'(rf_we),   32'd1);
      check("lat_rd",   32'(rf_rd),   32'd5);
      check("lat_data", 32'(rf_data), 32'hBEEF);
      step(1'b0, '0, '0, 1'b0);

      // Register 0 is accepted but never written.
      step(1'b1, '0, 16'h1234, 1'b0);
      step(1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0);

      // Full queue under read pressure, with a push held against it, then drain in order.
      for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), DW'(16'h2000 + i), 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, AW'(9), 16'h9999, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, '0, '0, 1'b0);

      // Same-register back-to-back pushes.
      step(1'b1, AW'(7), 16'd1, 1'b1);
      step(1'b1, AW'(7), 16'd2, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 1200; n++) begin
         if (n % 300 == 299) do_reset();
         step($urandom_range(0, 9) < 6, AW'($urandom_range(0, 7)), DW'($urandom),
              $urandom_range(0, 9) < 6);
      end

      for (int i = 0; i < 12; i++) step(1'b0, '0, '0, 1'b0);
      repeat (2) @(negedge clk);
      #1;
      check("drain_outstanding", 32'(exp_q.size()), 32'd0);
      check("drain_empty",       32'(empty),        32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
